axi_ddr_memtest: RTL and testbench

- AXI4 initiator (built-in self-test engine) that drives the user AXI port of the DDR3 controller wrapper from the user clock domain.
- After controller init completes and a start pulse arrives, it writes a deterministic pattern over a configurable region in fixed-length INCR bursts, then reads the region back and compares.
- Reports pass/fail, a saturating error count and the first failing beat address.
- Used for board bring-up and as a traffic source in DDR simulations.

---
 rtl/axi_ddr_memtest_pkg.sv | 20 ++
 rtl/axi_ddr_memtest_pattern_gen.sv | 38 +++
 rtl/axi_ddr_memtest.sv | 188 ++++++++++++++++++
 tb/tb_axi_ddr_memtest.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ddr_memtest_pkg.sv
// axi_ddr_memtest_pkg: shared FSM state, AXI encodings and LFSR taps for the DDR memory test engine.
package axi_ddr_memtest_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [3:0]  AXI_SIZE_8B    = 4'd3;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    // Galois taps 64,63,61,60 for a right-shifting register
    localparam logic [63:0] LFSR_TAPS      = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/axi_ddr_memtest_pattern_gen.sv
// memtest_pattern_gen: expected beat data, address-derived by default or from a 64-bit LFSR
// when MEMTEST_LFSR_EN is defined.
module memtest_pattern_gen
    import axi_ddr_memtest_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [28:0] i_addr,
    input  logic [31:0] i_seed,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [63:0] o_data
);

`ifdef MEMTEST_LFSR_EN
    logic [63:0] r_lfsr;
    logic        w_unused;

    assign w_unused = ^i_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= '0;
        else if (i_load)
            r_lfsr <= {i_seed, ~i_seed};
        else if (i_advance)
            r_lfsr <= {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 64'h0);
    end

    assign o_data = r_lfsr;
`else
    logic w_unused;

    assign w_unused = ^{clk, rst_n, i_load, i_advance};
    assign o_data   = {i_seed ^ {3'b0, i_addr}, ~{3'b0, i_addr}};
`endif

endmodule

// File: rtl/axi_ddr_memtest.sv
// axi_ddr_memtest: AXI4 write-then-read-back BIST engine for the DDR controller user port.
// Optional MEMTEST_LFSR_EN selects LFSR data instead of the address-derived pattern.
module axi_ddr_memtest
    import axi_ddr_memtest_pkg::*;
#(
    parameter int          ID_WIDTH   = 1,
    parameter logic [28:0] BASE_ADDR  = 29'h0000000,
    parameter int          NUM_BURSTS = 16,
    parameter int          BURST_LEN  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_init_done,
    input  logic                i_start,
    input  logic [31:0]         i_seed,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_fail,
    output logic [15:0]         o_err_count,
    output logic [28:0]         o_err_addr,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [28:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [3:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic [ID_WIDTH-1:0] o_arid,
    output logic [28:0]         o_araddr,
    output logic [7:0]          o_arlen,
    output logic [3:0]          o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [ID_WIDTH-1:0] i_rid,
    input  logic [63:0]         i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready
);

    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [28:0] BURST_BYTES = 29'(BURST_LEN * 8);

    state_t      r_state, w_next;
    logic [31:0] r_seed;
    logic [15:0] r_burst;
    logic [7:0]  r_beat;
    logic        r_done;
    logic [15:0] r_err_count;
    logic [28:0] r_err_addr;

    logic        w_start, w_last_beat, w_last_burst;
    logic        w_hs_w, w_hs_b, w_hs_r;
    logic [28:0] w_burst_base, w_beat_addr;
    logic [31:0] w_seed;
    logic [63:0] w_wr_pat, w_rd_pat;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;
    logic        w_unused;

    assign w_unused     = ^{i_bid, i_rid};
    assign w_start      = i_start & i_init_done & (r_state == S_IDLE);
    assign w_last_beat  = r_beat == LAST_BEAT;
    assign w_last_burst = r_burst == LAST_BURST;
    assign w_burst_base = BASE_ADDR + 29'(r_burst) * BURST_BYTES;
    assign w_beat_addr  = w_burst_base + {18'b0, r_beat, 3'b0};
    assign w_hs_w       = o_wvalid & i_wready;
    assign w_hs_b       = o_bready & i_bvalid;
    assign w_hs_r       = o_rready & i_rvalid;
    assign w_seed       = w_start ? i_seed : r_seed;

    // A read beat can carry up to three independent faults (data, resp, rlast)
    assign w_err_inc = {1'b0, w_hs_b & (i_bresp != AXI_RESP_OKAY)}
                     + {1'b0, w_hs_r & (i_rdata != w_rd_pat)}
                     + {1'b0, w_hs_r & (i_rresp != AXI_RESP_OKAY)}
                     + {1'b0, w_hs_r & (i_rlast != w_last_beat)};
    assign w_err_sum = {1'b0, r_err_count} + 17'(w_err_inc);

    memtest_pattern_gen u_wr_pat (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr    (w_beat_addr),
        .i_seed    (w_seed),
        .i_load    (w_start),
        .i_advance (w_hs_w),
        .o_data    (w_wr_pat)
    );

    memtest_pattern_gen u_rd_pat (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr    (w_beat_addr),
        .i_seed    (w_seed),
        .i_load    (w_start | (w_hs_b & w_last_burst)),
        .i_advance (w_hs_r),
        .o_data    (w_rd_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_start ? S_WR_ADDR : S_IDLE;
            S_WR_ADDR: w_next = i_awready ? S_WR_DATA : S_WR_ADDR;
            S_WR_DATA: w_next = (i_wready && w_last_beat) ? S_WR_RESP : S_WR_DATA;
            S_WR_RESP: w_next = i_bvalid ? (w_last_burst ? S_RD_ADDR : S_WR_ADDR) : S_WR_RESP;
            S_RD_ADDR: w_next = i_arready ? S_RD_DATA : S_RD_ADDR;
            S_RD_DATA: w_next = (i_rvalid && w_last_beat) ? (w_last_burst ? S_DONE : S_RD_ADDR) : S_RD_DATA;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_awvalid = r_state == S_WR_ADDR;
        o_wvalid  = r_state == S_WR_DATA;
        o_bready  = r_state == S_WR_RESP;
        o_arvalid = r_state == S_RD_ADDR;
        o_rready  = r_state == S_RD_DATA;
        o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else if (w_start) begin
            r_seed      <= i_seed;
            r_burst     <= '0;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            if (w_hs_w || w_hs_r)
                r_beat <= w_last_beat ? '0 : r_beat + 8'd1;
            if (w_hs_b || (w_hs_r && w_last_beat))
                r_burst <= w_last_burst ? '0 : r_burst + 16'd1;
            if (w_next == S_DONE)
                r_done <= 1'b1;
            if (w_err_inc != 2'd0) begin
                r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                if (r_err_count == 16'd0)
                    r_err_addr <= w_hs_b ? w_burst_base : w_beat_addr;
            end
        end
    end

    assign o_done      = r_done;
    assign o_fail      = r_err_count != 16'd0;
    assign o_err_count = r_err_count;
    assign o_err_addr  = r_err_addr;
    assign o_awid      = '0;
    assign o_awaddr    = w_burst_base;
    assign o_awlen     = LAST_BEAT;
    assign o_awsize    = AXI_SIZE_8B;
    assign o_awburst   = AXI_BURST_INCR;
    assign o_wdata     = w_wr_pat;
    assign o_wstrb     = 8'hFF;
    assign o_wlast     = o_wvalid & w_last_beat;
    assign o_arid      = '0;
    assign o_araddr    = w_burst_base;
    assign o_arlen     = LAST_BEAT;
    assign o_arsize    = AXI_SIZE_8B;
    assign o_arburst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_ddr_memtest.sv
// tb_axi_ddr_memtest: self-checking bench with an AXI memory responder, per-beat scoreboard
// and a table of whole-test scenarios (stalls, corrupted read, bad bresp).
module tb_axi_ddr_memtest;

    localparam int          NB   = 4;
    localparam int          BL   = 8;
    localparam int          N    = NB * BL;
    localparam logic [28:0] BASE = 29'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_init_done, i_start;
    logic [31:0] i_seed;
    logic        o_busy, o_done, o_fail;
    logic [15:0] o_err_count;
    logic [28:0] o_err_addr;
    logic [0:0]  o_awid, o_arid, i_bid, i_rid;
    logic [28:0] o_awaddr, o_araddr;
    logic [7:0]  o_awlen, o_arlen, o_wstrb;
    logic [3:0]  o_awsize, o_arsize;
    logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
    logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
    logic        o_arvalid, i_arready, i_rlast, i_rvalid, o_rready;
    logic [63:0] o_wdata, i_rdata;

    always #5 clk = ~clk;

    axi_ddr_memtest #(.ID_WIDTH(1), .BASE_ADDR(BASE), .NUM_BURSTS(NB), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .i_init_done(i_init_done), .i_start(i_start), .i_seed(i_seed),
        .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_err_count(o_err_count), .o_err_addr(o_err_addr),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] l);
        return {1'b0, l[63:1]} ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    typedef struct {
        logic [31:0] seed;
        bit          stall;
        bit          flip;
        logic [1:0]  bresp;
        logic        fail;
        logic [15:0] cnt;
        logic [28:0] addr;
    } vec_t;
    vec_t v [5];

    // scoreboard and responder state
    logic [63:0] exp_w_q [$];
    logic [28:0] exp_aw_q [$];
    logic [28:0] exp_ar_q [$];
    logic [63:0] mem [N];
    bit          stall, flip_en;
    logic [28:0] flip_addr = 29'h18;
    logic [1:0]  bresp_val;
    int          w_count, r_count, b_pending, r_left, r_beat;
    logic [28:0] w_addr_cur, r_addr_cur;
    logic [63:0] first_wdata, p_wdata;
    logic [28:0] p_awaddr, p_araddr;
    logic        p_aw_stall, p_w_stall, p_ar_stall, p_wlast;
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r, done_next;

    initial begin
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        i_bresp = 0; i_rresp = 0; i_rlast = 0; i_rdata = 0; i_bid = 0; i_rid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0; i_rlast = 0;
                b_pending = 0; r_left = 0; done_next = 0;
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0;
                continue;
            end
            if (p_aw_stall) chk("aw_stable", {o_awvalid, o_awaddr}, {1'b1, p_awaddr});
            if (p_w_stall)  chk("w_stable", {o_wvalid, o_wlast, o_wdata}, {1'b1, p_wlast, p_wdata});
            if (p_ar_stall) chk("ar_stable", {o_arvalid, o_araddr}, {1'b1, p_araddr});
            if (o_awvalid)  chk("w_during_aw", o_wvalid, 1'b0);
            if (done_next) begin
                chk("done_timing", {o_done, o_busy}, 2'b10);
                done_next = 0;
            end
            if (hs_b) i_bvalid = 0;
            if (hs_r) i_rvalid = 0;
            i_awready = stall ? 1'($urandom_range(1)) : 1'b1;
            i_wready  = stall ? 1'($urandom_range(1)) : 1'b1;
            i_arready = stall ? 1'($urandom_range(1)) : 1'b1;
            if (!i_bvalid && b_pending > 0 && (!stall || $urandom_range(1) == 1)) begin
                i_bvalid = 1;
                i_bresp  = bresp_val;
            end
            if (!i_rvalid && r_left > 0 && (!stall || $urandom_range(1) == 1)) begin
                i_rvalid = 1;
                i_rdata  = mem[int'((r_addr_cur - BASE) >> 3) % N] ^ 64'(flip_en && r_addr_cur == flip_addr);
                i_rresp  = 2'b00;
                i_rlast  = r_beat == BL - 1;
            end
            hs_aw = o_awvalid & i_awready;
            hs_w  = o_wvalid & i_wready;
            hs_b  = o_bready & i_bvalid;
            hs_ar = o_arvalid & i_arready;
            hs_r  = o_rready & i_rvalid;
            p_aw_stall = o_awvalid & !i_awready; p_awaddr = o_awaddr;
            p_w_stall  = o_wvalid & !i_wready;   p_wdata  = o_wdata; p_wlast = o_wlast;
            p_ar_stall = o_arvalid & !i_arready; p_araddr = o_araddr;
            if (hs_aw) begin
                if (exp_aw_q.size() == 0) chk("aw_extra", 1'b1, 1'b0);
                else chk("awaddr", o_awaddr, exp_aw_q.pop_front());
                chk("aw_fields", {o_awid, o_awlen, o_awsize, o_awburst, o_wstrb}, {1'b0, 8'(BL - 1), 4'd3, 2'b01, 8'hFF});
                w_addr_cur = o_awaddr;
            end
            if (hs_w) begin
                if (exp_w_q.size() == 0) chk("w_extra", 1'b1, 1'b0);
                else chk("wdata", o_wdata, exp_w_q.pop_front());
                chk("wlast", o_wlast, ((w_addr_cur - BASE) >> 3) % BL == BL - 1);
                if (w_count == 0) first_wdata = o_wdata;
                mem[int'((w_addr_cur - BASE) >> 3) % N] = o_wdata;
                w_addr_cur = w_addr_cur + 29'd8;
                w_count++;
                if (o_wlast) b_pending++;
            end
            if (hs_b) b_pending--;
            if (hs_ar) begin
                if (exp_ar_q.size() == 0) chk("ar_extra", 1'b1, 1'b0);
                else chk("araddr", o_araddr, exp_ar_q.pop_front());
                chk("ar_fields", {o_arid, o_arlen, o_arsize, o_arburst}, {1'b0, 8'(BL - 1), 4'd3, 2'b01});
                r_addr_cur = o_araddr;
                r_left = BL;
                r_beat = 0;
            end
            if (hs_r) begin
                r_addr_cur = r_addr_cur + 29'd8;
                r_beat++;
                r_left--;
                r_count++;
                if (r_count == N) done_next = 1;
            end
        end
    end

    task automatic start_test(input logic [31:0] seed, input bit st, input bit fl, input logic [1:0] br);
        logic [63:0] l;
        logic [28:0] a;
        stall = st; flip_en = fl; bresp_val = br;
        w_count = 0; r_count = 0;
        exp_w_q.delete(); exp_aw_q.delete(); exp_ar_q.delete();
        l = {seed, ~seed};
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < BL; k++) begin
                a = BASE + 29'((b * BL + k) * 8);
                if (k == 0) begin
                    exp_aw_q.push_back(a);
                    exp_ar_q.push_back(a);
                end
`ifdef MEMTEST_LFSR_EN
                exp_w_q.push_back(l);
                l = lfsr_next(l);
`else
                exp_w_q.push_back({seed ^ {3'b0, a}, ~{3'b0, a}});
`endif
            end
        end
        @(negedge clk);
        i_seed = seed; i_start = 1;
        @(negedge clk);
        i_start = 0; i_seed = ~seed;
        chk("after_start", {o_busy, o_done, o_fail, o_err_count}, {3'b100, 16'd0});
    endtask

    task automatic finish_test(input logic [31:0] seed);
        repeat (10) @(negedge clk);
        i_seed = ~seed; i_start = 1;
        @(negedge clk);
        i_start = 0;
        for (int i = 0; i < 4000 && !o_done; i++) @(negedge clk);
        chk("done_reached", {o_done, o_busy}, 2'b10);
        chk("beat_counts", {32'(w_count), 32'(r_count), 32'(exp_w_q.size())}, {32'(N), 32'(N), 32'd0});
    endtask

    initial begin
        v[0] = '{32'hA5A5A5A5, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 29'h0};
        v[1] = '{32'h12345678, 1'b0, 1'b1, 2'b00, 1'b1, 16'd1, 29'h18};
        v[2] = '{32'hA5A5A5A5, 1'b1, 1'b0, 2'b00, 1'b0, 16'd0, 29'h0};
        v[3] = '{32'hDEADBEEF, 1'b0, 1'b0, 2'b10, 1'b1, 16'd4, BASE};
        v[4] = '{32'h0F0F1234, 1'b1, 1'b1, 2'b00, 1'b1, 16'd1, 29'h18};
        rst_n = 0; i_init_done = 0; i_start = 0; i_seed = 0;
        stall = 0; flip_en = 0; bresp_val = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_busy, o_done, o_fail}, 8'h00);
        chk("reset_err", {o_err_count, o_err_addr}, 45'h0);
        rst_n = 1;
        i_start = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_init_idle", {o_awvalid, o_wvalid, o_arvalid, o_busy}, 4'h0);
        end
        i_start = 0;
        i_init_done = 1;
        for (int t = 0; t < 5; t++) begin
            start_test(v[t].seed, v[t].stall, v[t].flip, v[t].bresp);
            finish_test(v[t].seed);
            chk($sformatf("result_%0d", t), {o_fail, o_err_count, o_err_addr}, {v[t].fail, v[t].cnt, v[t].addr});
            if (t == 0)
`ifdef MEMTEST_LFSR_EN
                chk("beat0", first_wdata, 64'hA5A5A5A5_5A5A5A5A);
`else
                chk("beat0", first_wdata, 64'hA5A5A5A5_FFFFFFFF);
`endif
        end
        // reset in the middle of the first write burst, then a clean rerun
        start_test(32'h5555AAAA, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 200 && w_count < 3; i++) @(posedge clk);
        chk("reached_beat3", w_count >= 3, 1'b1);
        #2 rst_n = 0;
        #1 chk("async_reset", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_busy, o_done}, 7'h00);
        repeat (2) @(negedge clk);
        rst_n = 1;
        start_test(32'h5555AAAA, 1'b0, 1'b0, 2'b00);
        finish_test(32'h5555AAAA);
        chk("after_reset_clean", {o_fail, o_err_count, o_err_addr}, 46'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
